av_config_sequencer: RTL and testbench

Avalon-MM master that sits directly upstream of the audio/video config slave and drives its ob_* port. It accepts one codec register write request (7-bit register address, 9-bit value) and turns it into the slave's I2C command sequence. The sequence is: wait for auto-init, START plus device address, two data bytes, STOP, check ACK, clear status. It reports done/error to the requesting logic, such as the oscilloscope's volume or input-select control.

---
 rtl/av_config_sequencer.sv | 150 +++++++++++++++
 tb/tb_av_config_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/av_config_sequencer.sv
// Avalon-MM master turning one codec register write into the A/V config slave's I2C command sequence.
// Latency: 8 cycles accept-to-done with no stalls; requests are taken only in IDLE and never queued.
module av_config_sequencer #(
    parameter int unsigned                TIMEOUT_BITS   = 20,
    parameter logic [TIMEOUT_BITS-1:0]    TIMEOUT_CYCLES = 20'hFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_reg_addr,
    input  logic [8:0]  req_reg_data,
    output logic        done,
    output logic        error,
    output logic        busy,
    output logic [2:0]  ob_address,
    output logic [3:0]  ob_byteenable,
    output logic        ob_chipselect,
    output logic        ob_read,
    output logic        ob_write,
    output logic [31:0] ob_writedata,
    input  logic [31:0] ob_readdata,
    input  logic        ob_waitrequest
);

    typedef enum logic [3:0] {
        S_IDLE, S_POLL_INIT, S_WR_START, S_WR_BYTE1, S_WR_BYTE2,
        S_WR_STOP, S_RD_STATUS, S_CLR_STATUS, S_DONE
    } state_t;

    localparam logic [TIMEOUT_BITS-1:0] LP_TMAX = TIMEOUT_CYCLES - 1'b1;

    state_t                  r_state;
    state_t                  w_next;
    logic [TIMEOUT_BITS-1:0] r_timer;
    logic [6:0]              r_reg_addr;
    logic [8:0]              r_reg_data;
    logic                    r_error;
    logic                    w_stepping;
    logic                    w_advance;
    logic                    w_timeout;
    logic                    w_accept;
    logic                    w_nak;
    logic                    w_unused_rd;

    assign w_stepping = (r_state != S_IDLE) && (r_state != S_DONE);
    // A poll read that reports init still busy completes on the bus but does not leave the state.
    assign w_advance  = !ob_waitrequest && !((r_state == S_POLL_INIT) && ob_readdata[2]);
    assign w_timeout  = w_stepping && !w_advance && (r_timer == LP_TMAX);
    assign w_accept   = (r_state == S_IDLE) && req_valid;
    assign w_nak      = (r_state == S_RD_STATUS) && !ob_waitrequest
                        && (ob_readdata[0] || ob_readdata[3]);
    assign w_unused_rd = ^{ob_readdata[31:4], ob_readdata[1]};

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_timeout) begin
            w_next = S_DONE;
        end else begin
            unique case (r_state)
                S_IDLE:       if (req_valid) w_next = S_POLL_INIT;
                S_POLL_INIT:  if (w_advance) w_next = S_WR_START;
                S_WR_START:   if (w_advance) w_next = S_WR_BYTE1;
                S_WR_BYTE1:   if (w_advance) w_next = S_WR_BYTE2;
                S_WR_BYTE2:   if (w_advance) w_next = S_WR_STOP;
                S_WR_STOP:    if (w_advance) w_next = S_RD_STATUS;
                S_RD_STATUS:  if (w_advance) w_next = S_CLR_STATUS;
                S_CLR_STATUS: if (w_advance) w_next = S_DONE;
                S_DONE:       w_next = S_IDLE;
                default:      w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ob_read      = 1'b0;
        ob_write     = 1'b0;
        ob_address   = 3'd0;
        ob_writedata = 32'd0;
        done         = 1'b0;
        unique case (r_state)
            S_POLL_INIT: begin
                ob_read    = 1'b1;
                ob_address = 3'd1;
            end
            S_WR_START: begin
                ob_write     = 1'b1;
                ob_address   = 3'd0;
                ob_writedata = 32'h4;
            end
            S_WR_BYTE1: begin
                ob_write     = 1'b1;
                ob_address   = 3'd2;
                ob_writedata = {24'd0, r_reg_addr, r_reg_data[8]};
            end
            S_WR_BYTE2: begin
                ob_write     = 1'b1;
                ob_address   = 3'd2;
                ob_writedata = {24'd0, r_reg_data[7:0]};
            end
            S_WR_STOP: begin
                ob_write     = 1'b1;
                ob_address   = 3'd0;
                ob_writedata = 32'h2;
            end
            S_RD_STATUS: begin
                ob_read    = 1'b1;
                ob_address = 3'd1;
            end
            S_CLR_STATUS: begin
                ob_write   = 1'b1;
                ob_address = 3'd1;
            end
            S_DONE:  done = 1'b1;
            default: done = 1'b0;
        endcase
        ob_chipselect = ob_read || ob_write;
        ob_byteenable = (ob_read || ob_write) ? 4'b0001 : 4'b0000;
        busy          = (r_state != S_IDLE);
        req_ready     = (r_state == S_IDLE);
        error         = r_error;
    end

    // The watchdog spans a whole state, so repeated init polls share one budget.
    always_ff @(posedge clk) begin
        if (!reset)                 r_timer <= '0;
        else if (r_state != w_next) r_timer <= '0;
        else if (w_stepping)        r_timer <= r_timer + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_reg_addr <= 7'd0;
            r_reg_data <= 9'd0;
            r_error    <= 1'b0;
        end else if (w_accept) begin
            r_reg_addr <= req_reg_addr;
            r_reg_data <= req_reg_data;
            r_error    <= 1'b0;
        end else if (w_timeout || w_nak) begin
            r_error    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_av_config_sequencer.sv
// Directed bench: table of requests against a small scripted slave, plus reset and timeout sequences.
module tb_av_config_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_reg_addr;
    logic [8:0]  req_reg_data;
    logic        done, error, busy;
    logic [2:0]  ob_address;
    logic [3:0]  ob_byteenable;
    logic        ob_chipselect, ob_read, ob_write;
    logic [31:0] ob_writedata;
    logic [31:0] ob_readdata;
    logic        ob_waitrequest;

    logic        t_req_valid, t_req_ready, t_done, t_error, t_busy;
    logic [2:0]  t_addr;
    logic [3:0]  t_be;
    logic        t_cs, t_rd, t_wr;
    logic [31:0] t_wdata;
    logic [31:0] t_rdata;
    logic        t_wait;
    assign t_rdata = 32'd0;
    assign t_wait  = t_wr;

    av_config_sequencer u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_reg_addr(req_reg_addr), .req_reg_data(req_reg_data),
        .done(done), .error(error), .busy(busy),
        .ob_address(ob_address), .ob_byteenable(ob_byteenable), .ob_chipselect(ob_chipselect),
        .ob_read(ob_read), .ob_write(ob_write), .ob_writedata(ob_writedata),
        .ob_readdata(ob_readdata), .ob_waitrequest(ob_waitrequest)
    );

    av_config_sequencer #(.TIMEOUT_BITS(20), .TIMEOUT_CYCLES(20'd16)) u_to (
        .clk(clk), .reset(reset), .req_valid(t_req_valid), .req_ready(t_req_ready),
        .req_reg_addr(req_reg_addr), .req_reg_data(req_reg_data),
        .done(t_done), .error(t_error), .busy(t_busy),
        .ob_address(t_addr), .ob_byteenable(t_be), .ob_chipselect(t_cs),
        .ob_read(t_rd), .ob_write(t_wr), .ob_writedata(t_wdata),
        .ob_readdata(t_rdata), .ob_waitrequest(t_wait)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scripted slave
    int          cfg_busy_reads = 0;
    int          cfg_stall_idx  = -1;
    int          cfg_stall_len  = 0;
    logic [31:0] cfg_status     = 32'd0;
    int          n_wr = 0, n_poll = 0, n_stall = 0;
    bit          m_accept, m_wr_cpl, m_rd_cpl, m_stall, m_poll;

    always_comb begin
        ob_waitrequest = 1'b0;
        if (ob_write && (n_wr == cfg_stall_idx) && (n_stall < cfg_stall_len))
            ob_waitrequest = 1'b1;
        ob_readdata = 32'd0;
        if (ob_read)
            ob_readdata = (n_wr == 0) ? ((n_poll < cfg_busy_reads) ? 32'h4 : 32'h0) : cfg_status;
    end

    typedef struct packed {
        logic        we;
        logic [2:0]  a;
        logic [31:0] d;
    } lg_t;
    lg_t  bus_log[$];
    lg_t  exp_q[$];
    int   n_bad = 0, n_unstable = 0;
    bit   prev_stall = 0;
    logic [36:0] prev_bus = '0;

    always @(negedge clk) begin
        lg_t e;
        m_accept = req_valid && req_ready && reset;
        m_wr_cpl = ob_write && !ob_waitrequest;
        m_rd_cpl = ob_read && !ob_waitrequest;
        m_stall  = ob_write && ob_waitrequest;
        m_poll   = (n_wr == 0);
        if (m_wr_cpl || m_rd_cpl) begin
            e.we = ob_write;
            e.a  = ob_address;
            e.d  = ob_write ? ob_writedata : 32'd0;
            bus_log.push_back(e);
        end
        if (((ob_read || ob_write) != ob_chipselect) || (ob_read && ob_write)
            || (ob_byteenable != ((ob_read || ob_write) ? 4'h1 : 4'h0))
            || (ob_writedata[31:8] != 24'd0)
            || (ob_write && ob_address == 3'd0 && ob_writedata[0]))
            n_bad++;
        if (prev_stall && ({ob_read, ob_write, ob_address, ob_writedata} != prev_bus))
            n_unstable++;
        prev_stall = ob_waitrequest && (ob_read || ob_write);
        prev_bus   = {ob_read, ob_write, ob_address, ob_writedata};
    end

    always @(posedge clk) begin
        if (m_accept) begin
            n_wr <= 0; n_poll <= 0; n_stall <= 0;
        end else begin
            if (m_wr_cpl) begin
                n_wr <= n_wr + 1; n_stall <= 0;
            end else if (m_stall) begin
                n_stall <= n_stall + 1;
            end
            if (m_rd_cpl && m_poll) n_poll <= n_poll + 1;
        end
    end

    typedef struct {
        logic [6:0]  ra;
        logic [8:0]  rd;
        int          busy_reads;
        logic [31:0] status;
        int          stall_idx;
        int          stall_len;
        bit          poke;
        logic [7:0]  exp_b1;
        logic [7:0]  exp_b2;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    task automatic chk_idle(input string p);
        chk({p, "_read"},  ob_read, 1'b0);
        chk({p, "_write"}, ob_write, 1'b0);
        chk({p, "_cs"},    ob_chipselect, 1'b0);
        chk({p, "_be"},    ob_byteenable, 4'h0);
        chk({p, "_addr"},  ob_address, 3'd0);
        chk({p, "_wdata"}, ob_writedata, 32'd0);
        chk({p, "_done"},  done, 1'b0);
        chk({p, "_error"}, error, 1'b0);
        chk({p, "_busy"},  busy, 1'b0);
        chk({p, "_ready"}, req_ready, 1'b1);
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int   lat;
        lg_t  e;
        string p;
        p = $sformatf("v%0d", id);
        cfg_busy_reads = v.busy_reads;
        cfg_status     = v.status;
        cfg_stall_idx  = v.stall_idx;
        cfg_stall_len  = v.stall_len;
        bus_log.delete();
        exp_q.delete();
        for (int k = 0; k <= v.busy_reads; k++) exp_q.push_back('{1'b0, 3'd1, 32'd0});
        exp_q.push_back('{1'b1, 3'd0, 32'h4});
        exp_q.push_back('{1'b1, 3'd2, {24'd0, v.exp_b1}});
        exp_q.push_back('{1'b1, 3'd2, {24'd0, v.exp_b2}});
        exp_q.push_back('{1'b1, 3'd0, 32'h2});
        exp_q.push_back('{1'b0, 3'd1, 32'd0});
        exp_q.push_back('{1'b1, 3'd1, 32'd0});

        @(posedge clk); #1;
        req_reg_addr = v.ra;
        req_reg_data = v.rd;
        req_valid    = 1'b1;
        @(negedge clk);
        chk({p, "_ready"}, req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({p, "_err_clr"}, error, 1'b0);
        chk({p, "_busy"}, busy, 1'b1);
        lat = -1;
        for (int c = 1; c <= 400; c++) begin
            if (v.poke && c == 2) begin
                req_valid = 1'b1; req_reg_addr = 7'h55; req_reg_data = 9'h1FF;
            end
            if (v.poke && c == 3) req_valid = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk({p, "_latency"}, lat, v.exp_lat);
        chk({p, "_err_done"}, error, v.exp_err);
        @(posedge clk); #1;
        chk({p, "_done_1cyc"}, done, 1'b0);
        chk({p, "_idle_ready"}, req_ready, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk({p, "_idle_busy"}, busy, 1'b0);
        chk({p, "_err_idle"}, error, v.exp_err);
        chk({p, "_nlog"}, bus_log.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < bus_log.size(); k++) begin
            e = bus_log[k];
            chk($sformatf("%s_bus%0d", p, k), e, exp_q[k]);
        end
    endtask

    vec_t vecs[6];
    int   nw;
    bit   stop_seen;
    bit   start_bad;

    initial begin
        vecs[0] = '{7'h04, 9'h17B, 0, 32'h0, -1, 0,  1'b0, 8'h09, 8'h7B, 1'b0, 8};
        vecs[1] = '{7'h04, 9'h17B, 0, 32'h0,  1, 50, 1'b0, 8'h09, 8'h7B, 1'b0, 58};
        vecs[2] = '{7'h7F, 9'h0FF, 3, 32'h0, -1, 0,  1'b0, 8'hFE, 8'hFF, 1'b0, 11};
        vecs[3] = '{7'h00, 9'h100, 0, 32'h1, -1, 0,  1'b0, 8'h01, 8'h00, 1'b1, 8};
        vecs[4] = '{7'h2A, 9'h055, 0, 32'h8, -1, 0,  1'b0, 8'h54, 8'h55, 1'b1, 8};
        vecs[5] = '{7'h11, 9'h0AA, 0, 32'h2, -1, 0,  1'b1, 8'h22, 8'hAA, 1'b0, 8};

        reset = 1'b0; req_valid = 1'b0; t_req_valid = 1'b0;
        req_reg_addr = 7'd0; req_reg_data = 9'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk_idle("rst");
        chk("rst_to_ready", t_req_ready, 1'b1);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);
        chk("stall_stable", n_unstable, 0);

        // Reset during WR_BYTE2 abandons the transfer without a STOP
        cfg_busy_reads = 0; cfg_status = 32'd0; cfg_stall_idx = -1; cfg_stall_len = 0;
        @(posedge clk); #1;
        req_reg_addr = 7'h04; req_reg_data = 9'h17B; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_b2_write", ob_write, 1'b1);
        chk("mid_b2_addr", ob_address, 3'd2);
        chk("mid_b2_data", ob_writedata, 32'h7B);
        bus_log.delete();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk_idle("mid_rst");
        repeat (4) @(posedge clk);
        #1;
        chk("mid_rst_quiet", bus_log.size(), 1);
        chk("mid_rst_busy", busy, 1'b0);

        // Watchdog on the short-timeout instance: write stuck in WR_START
        nw = 0; stop_seen = 1'b0; start_bad = 1'b0;
        @(posedge clk); #1;
        t_req_valid = 1'b1;
        @(posedge clk); #1;
        t_req_valid = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (t_wr) begin
                nw++;
                if (t_wdata == 32'h2) stop_seen = 1'b1;
                if (t_addr != 3'd0 || t_wdata != 32'h4) start_bad = 1'b1;
            end else if (nw > 0) begin
                break;
            end
            @(posedge clk); #1;
        end
        chk("to_strobe_cycles", nw, 16);
        chk("to_start_data", start_bad, 1'b0);
        chk("to_done", t_done, 1'b1);
        chk("to_error", t_error, 1'b1);
        @(posedge clk); #1;
        chk("to_done_1cyc", t_done, 1'b0);
        chk("to_idle", t_busy, 1'b0);
        chk("to_err_sticky", t_error, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("to_no_write", t_wr, 1'b0);
        chk("to_no_stop", stop_seen, 1'b0);

        chk("bus_rules", n_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
